// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts one ALU instruction, reads operands, drives the ALU,
// writes the result back and updates the architectural F/Z/N flags in psr_flags.
module alu_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_rdest,
  input  logic [ADDR_W-1:0] req_rsrc,
  input  logic              req_imm_en,
  input  logic [IMM_W-1:0]  req_imm,
  output logic [ADDR_W-1:0] rf_raddr_a,
  output logic [ADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [DATA_W-1:0] alu_reg1,
  output logic [DATA_W-1:0] alu_reg2,
  output logic [3:0]        alu_inst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_flagreg,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] psr_flags,
  output logic              done,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  state_t             state;
  logic [3:0]         op;
  logic [ADDR_W-1:0]  rdest;
  logic [ADDR_W-1:0]  rsrc;
  logic               imm_en;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  result;
  logic [2:0]         flag_cap;
  logic [DATA_W-1:0]  imm_ext;
  logic               legal_op;
  logic               arith_op;
  logic               unused_flag_bits;

  always_comb begin
    legal_op = 1'b0;
    case (req_op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  assign arith_op = (op == 4'b0000) || (op == 4'b1000);
  assign imm_ext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rf_raddr_a = rdest;
  assign rf_raddr_b = rsrc;
  assign rf_waddr   = rdest;
  assign rf_wdata   = result;

  // Only F (bit 2), Z (bit 3) and N (bit 4) of the ALU flag word are architectural.
  assign unused_flag_bits = ^{alu_flagreg[DATA_W-1:5], alu_flagreg[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= '0;
      rdest     <= '0;
      rsrc      <= '0;
      imm_en    <= 1'b0;
      imm       <= '0;
      alu_reg1  <= '0;
      alu_reg2  <= '0;
      alu_inst  <= '0;
      result    <= '0;
      flag_cap  <= '0;
      psr_flags <= '0;
      rf_we     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op     <= req_op;
            rdest  <= req_rdest;
            rsrc   <= req_rsrc;
            imm_en <= req_imm_en;
            imm    <= req_imm;
            if (legal_op) begin
              state <= READ;
            end else begin
              state <= ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        READ: begin
          alu_reg1 <= rf_rdata_a;
          alu_reg2 <= imm_en ? imm_ext : rf_rdata_b;
          alu_inst <= op;
          state    <= EXEC;
        end
        // Pulses are raised here so they are high for exactly the WB cycle.
        EXEC: begin
          result   <= alu_result;
          flag_cap <= alu_flagreg[4:2];
          rf_we    <= 1'b1;
          done     <= 1'b1;
          state    <= WB;
        end
        WB: begin
          if (arith_op) psr_flags[4:2] <= flag_cap;
          else          psr_flags[3]   <= flag_cap[1];
          state <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle sequencer between the register file and the combinational ALU (ALU ports: reg1, reg2, inst[3:0], result, flagreg[15:0]).
- Accepts one ALU instruction per valid/ready handshake, then runs four steps in order: read operands, drive the ALU, write the result back, update the processor flag register.
- Sits in the execute stage and owns the architectural flag bits F (bit 2), Z (bit 3) and N (bit 4).

Parameters:
DATA_W, 16, datapath and flag-register width
ADDR_W, 4, register-file address width (16 registers)
IMM_W, 8, immediate width; sign-extended to DATA_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  instruction request valid
req_ready  output  1  controller can accept a request (high only in IDLE)
req_op  input  4  ALU opcode: 0000 ADD, 1000 SUB, 0001 AND, 0010 OR, 0011 XOR
req_rdest  input  ADDR_W  destination register; also the first operand
req_rsrc  input  ADDR_W  second-operand register
req_imm_en  input  1  1 = second operand is the immediate, not rsrc
req_imm  input  IMM_W  immediate value
rf_raddr_a  output  ADDR_W  register-file read address A
rf_raddr_b  output  ADDR_W  register-file read address B
rf_rdata_a  input  DATA_W  read data A (combinational register file)
rf_rdata_b  input  DATA_W  read data B
alu_reg1  output  DATA_W  ALU operand 1 (registered)
alu_reg2  output  DATA_W  ALU operand 2 (registered)
alu_inst  output  4  ALU opcode (registered)
alu_result  input  DATA_W  ALU result
alu_flagreg  input  DATA_W  ALU flag outputs
rf_we  output  1  register-file write enable, one-cycle pulse
rf_waddr  output  ADDR_W  write address
rf_wdata  output  DATA_W  write data
psr_flags  output  DATA_W  architectural flag register
done  output  1  one-cycle completion pulse
err  output  1  one-cycle illegal-opcode pulse, coincident with done
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all registered outputs 0; psr_flags=0; rf_we, done and err are 0.
- States: IDLE, READ, EXEC, WB, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge: latch op, rdest, rsrc, imm_en and imm.
  - Legal opcode -> READ; illegal opcode -> ERR.
- READ:
  - rf_raddr_a=rdest, rf_raddr_b=rsrc.
  - At the edge: alu_reg1<=rf_rdata_a; alu_reg2<=(imm_en ? sign-extended imm : rf_rdata_b); alu_inst<=op.
  - -> EXEC.
- EXEC:
  - ALU settles.
  - At the edge: capture alu_result into the write-data register and alu_flagreg into a flag-capture register.
  - -> WB.
- WB:
  - rf_we=1, rf_waddr=rdest, rf_wdata=captured result; done=1.
  - At the edge: psr_flags updated per the rules below.
  - -> IDLE.
- ERR: done=1, err=1; no register-file write; psr_flags unchanged. -> IDLE.
- Flag update rules:
  - ADD/SUB: psr bits 2, 3 and 4 take the captured ALU flags.
  - AND/OR/XOR: only bit 3 (Z) is updated.
  - All other psr bits are preserved.
- Timing:
  - Accept at edge N; done and rf_we are high in the cycle after edge N+2; new psr_flags are visible after edge N+3.
  - Throughput: one instruction per 4 cycles.
- Handshake: req_ready is low in READ, EXEC, WB and ERR. A request held across busy is accepted at the first edge in IDLE, i.e. the edge after WB.
- Width: arithmetic is modulo 2^DATA_W, performed by the ALU; the controller does no arithmetic except immediate sign extension.
- rf_we, done and err are exactly one cycle wide; rf_waddr and rf_wdata are stable throughout WB.
- Reset asserted mid-operation: the operation is abandoned; no rf_we; psr_flags=0; req_ready=1 on the first edge after reset deasserts.
- rdest==rsrc is legal: both operands read the same register.

Test Plan:
- ADD, r1=5, r2=7, imm_en=0 -> rf_we pulse, waddr=1, wdata=0x000C, done 3 cycles after accept; psr F=0 Z=0 N=0.
- SUB, r3=3, r4=3 -> wdata=0x0000, psr Z=1, N=0, F=0; then SUB r2=2, r5=5 -> wdata=0xFFFD, N=1, Z=0.
- ADD, r6=0x7FFF, imm=0x01 -> wdata=0x8000, psr F=1, N=1, Z=0; then AND r7=0x000C, imm=0x0A -> wdata=0x0008, Z=0, F and N still 1.
- Immediate sign extension: OR r0=0x0000, imm=0xF0 -> wdata=0xFFF0; psr bit 3 cleared; other bits unchanged.
- Illegal op 0100 -> err and done both high for one cycle, 1 cycle after accept; no rf_we; psr_flags unchanged.
- req_valid held high through busy -> back-to-back accepts exactly 4 cycles apart. Then assert reset during EXEC -> no rf_we pulse, psr_flags=0, req_ready=1 after reset deasserts.
